// File: rtl/display_scan_ctrl.sv
// Four-digit seven-segment scan scheduler.
// Blanking gap between digits, blinking of one digit pair in adjust mode.
module display_scan_ctrl #(
  parameter int SCAN_DIV  = 100000,
  parameter int BLANK_CYC = 2000,
  parameter int BLINK_DIV = 50000000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] digit0_display,
  input  logic [7:0] digit1_display,
  input  logic [7:0] digit2_display,
  input  logic [7:0] digit3_display,
  input  logic       adj,
  input  logic       sel,
  output logic [7:0] seg,
  output logic [3:0] an,
  output logic [1:0] scan_idx
);

  localparam int CW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int BW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

  localparam logic [CW-1:0] CNT_LAST   = CW'(SCAN_DIV - 1);
  localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK_CYC - 1);
  localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_DIV - 1);

  typedef enum logic {
    BLANK,
    SHOW
  } state_t;

  state_t          state;
  state_t          state_nx;
  logic [CW-1:0]   cnt;
  logic [CW-1:0]   cnt_nx;
  logic [1:0]      idx_nx;
  logic [BW-1:0]   blink_cnt;
  logic [BW-1:0]   blink_cnt_nx;
  logic            blink_on;
  logic            blink_on_nx;
  logic            suppress;
  logic [7:0]      seg_nx;
  logic [3:0]      an_nx;

  // Scan state, dwell counter and slot index.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= BLANK;
      cnt      <= '0;
      scan_idx <= 2'd0;
    end else begin
      state    <= state_nx;
      cnt      <= cnt_nx;
      scan_idx <= idx_nx;
    end
  end

  // Slot sequencing: blank first, then show until the slot ends.
  always_comb begin
    state_nx = state;
    cnt_nx   = cnt + CW'(1);
    idx_nx   = scan_idx;
    unique case (state)
      BLANK: begin
        if (cnt == BLANK_LAST) state_nx = SHOW;
      end
      SHOW: begin
        if (cnt == CNT_LAST) begin
          state_nx = BLANK;
          cnt_nx   = '0;
          idx_nx   = scan_idx + 2'd1;
        end
      end
      default: state_nx = BLANK;
    endcase
  end

  // Blink phase generator, parked in the visible phase outside adjust mode.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      blink_cnt <= '0;
      blink_on  <= 1'b1;
    end else begin
      blink_cnt <= blink_cnt_nx;
      blink_on  <= blink_on_nx;
    end
  end

  // Blink counter wrap and phase toggle.
  always_comb begin
    blink_cnt_nx = blink_cnt + BW'(1);
    blink_on_nx  = blink_on;
    unique case (1'b1)
      !adj: begin
        blink_cnt_nx = '0;
        blink_on_nx  = 1'b1;
      end
      (blink_cnt == BLINK_LAST): begin
        blink_cnt_nx = '0;
        blink_on_nx  = ~blink_on;
      end
      default: ;
    endcase
  end

  // Output decode: dark unless showing an unsuppressed slot.
  always_comb begin
    suppress = adj & ~blink_on & (scan_idx[1] == sel);
    an_nx    = 4'hF;
    seg_nx   = 8'hFF;
    if (state == SHOW && !suppress) begin
      an_nx = ~(4'b0001 << scan_idx);
      unique case (scan_idx)
        2'd0: seg_nx = digit0_display;
        2'd1: seg_nx = digit1_display;
        2'd2: seg_nx = digit2_display;
        2'd3: seg_nx = digit3_display;
        default: seg_nx = 8'hFF;
      endcase
    end
  end

  // Pin register: anodes and cathodes switch on the same edge.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      seg <= 8'hFF;
      an  <= 4'hF;
    end else begin
      seg <= seg_nx;
      an  <= an_nx;
    end
  end

endmodule
